// File: rtl/call_stack.sv
// LIFO return-address/data stack for CALL/RET and PUSH/POP.
// Register-based storage, top of stack visible combinationally on D_OUT.
module call_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PUSH,
  input  logic             POP,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             CLR_ERR,
  output logic [WIDTH-1:0] D_OUT,
  output logic [PTR_W:0]   COUNT,
  output logic             EMPTY,
  output logic             FULL,
  output logic             ERR
);

  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_m1;
  logic [PTR_W:0]   count_nxt;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             do_write;
  logic             err_set;
  logic             err_q;

  assign count_m1 = count_q - CNT_ONE;
  assign top_idx  = count_m1[PTR_W-1:0];

  assign EMPTY = (count_q == '0);
  assign FULL  = (count_q == CNT_FULL);
  assign COUNT = count_q;
  assign ERR   = err_q;
  // Words above COUNT are stale and must never reach D_OUT.
  assign D_OUT = EMPTY ? '0 : mem[top_idx];

  always_comb begin
    do_write  = 1'b0;
    wr_idx    = count_q[PTR_W-1:0];
    count_nxt = count_q;
    err_set   = 1'b0;
    case ({PUSH, POP})
      2'b10: begin
        if (FULL) begin
          err_set = 1'b1;
        end else begin
          do_write  = 1'b1;
          count_nxt = count_q + CNT_ONE;
        end
      end
      2'b01: begin
        if (EMPTY) err_set = 1'b1;
        else       count_nxt = count_m1;
      end
      2'b11: begin
        // Push+pop on an empty stack degenerates to a plain push.
        do_write = 1'b1;
        if (EMPTY) begin
          wr_idx    = '0;
          count_nxt = CNT_ONE;
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count_q <= count_nxt;
      if (do_write) mem[wr_idx] <= D_IN;
      // Set wins over clear when both happen on the same edge.
      if (err_set)      err_q <= 1'b1;
      else if (CLR_ERR) err_q <= 1'b0;
    end
  end

endmodule
